keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  4x4 matrix keypad scanner and debouncer. Drives the column lines one at a time and samples the row lines.
//  Debounces each of the 16 keys and produces one-cycle press pulses key_pulse[15:0].
//  key_pulse is the producer side of the sticky key register that feeds the APB keyboard peripheral.
//  Key index i = row*4 + col.
// PARAMETERS
//  SCAN_DIV        4   clk cycles per column slot; legal range >=4. Row lines settle within the slot.
//  DEBOUNCE_SCANS  3   consecutive full frames a key must differ from key_state before key_state flips; >=1.
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset: asynchronous, active-high
//  row          in   4   keypad rows: async, pulled up, active-low (0 = key pressed in driven column)
//  col          out  4   keypad columns: active-low, exactly one bit low at any time
//  key_state    out  16  debounced level, 1 = held
//  key_pulse    out  16  1-cycle pulse on debounced press (key_state bit 0->1)
//  key_release  out  16  1-cycle pulse on debounced release (key_state bit 1->0)
//  frame_done   out  1   1-cycle pulse, one per completed 4-column frame
// BEHAVIOUR
//  Reset values:
//   - col=4'b1110; col_sel=0; div_cnt=0.
//   - row synchroniser flops = 4'b1111.
//   - key_state, key_pulse, key_release, all debounce counters = 0; frame_done=0.
//  Row synchroniser: row passes through 2 flops before use. No other use of the raw row.
//  Column scan:
//   - div_cnt counts 0..SCAN_DIV-1 and wraps.
//   - At div_cnt==SCAN_DIV-1 (last slot cycle), the synced row is captured into raw[r*4+col_sel] = ~row_sync[r].
//   - On that same edge col_sel increments (3 wraps to 0); col = ~(4'b0001 << col_sel).
//   - Frame length = 4*SCAN_DIV cycles.
//  Frame evaluation:
//   - Occurs on the edge after the column-3 capture; frame_done is high during that following cycle.
//   - Per key i:
//     - raw[i]==key_state[i]: cnt[i]<=0.
//     - else if cnt[i]==DEBOUNCE_SCANS-1: key_state[i] <= raw[i], cnt[i]<=0, and pulse asserted.
//     - else cnt[i]<=cnt[i]+1.
//   - cnt width = clog2(DEBOUNCE_SCANS)+1; the counter never saturates past DEBOUNCE_SCANS-1.
//  Pulse outputs:
//   - Registered, updated on the same edge as key_state.
//   - High for exactly one clk; otherwise 0.
//   - key_pulse and key_release of the same key are never simultaneously high.
//  Multiple keys:
//   - All 16 keys are independent.
//   - Several keys may flip, and pulse, in the same cycle.
//   - No ghost/anti-aliasing logic: three-key phantoms appear as real presses.
//  Latency: a press stable from the first frame in which it is captured gives key_pulse DEBOUNCE_SCANS frames later, at frame_done.
//  Bounce: any frame whose raw disagrees with the candidate resets that key's counter. Glitches shorter than DEBOUNCE_SCANS frames are suppressed.
//  Reset mid-operation:
//   - All state clears immediately and asynchronously; no pulse is generated by reset itself.
//   - A key held through reset release is re-detected: key_pulse occurs after DEBOUNCE_SCANS frames.
//  Row changes that occur between column slots are seen only at that column's next capture.
// TESTING  (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame=16 clk)
//  1 Reset asserted then released, no keys -> col=1110, all outputs 0. frame_done every 16 clk, first at cycle 17 after release.
//  2 Free-run 40 clk -> col steps 1110,1101,1011,0111 every 4 clk and wraps; exactly one 0 bit in col at all times.
//  3 Key 5 held continuously (row[1] low whenever col[1]==0) -> key_pulse==16'h0020 for 1 clk at the 3rd frame_done; key_state[5] then stays 1 with no further pulses.
//  4 Key 10 pressed for 2 frames then released -> no key_pulse, key_state stays 0. Re-press for 3 frames -> key_pulse[10].
//  5 Keys 0 and 15 pressed in the same frame, then released -> key_pulse==16'h8001 in one cycle. After release, key_release==16'h8001 three frames later.
//  6 rst pulsed while key 3 is at cnt=2 -> outputs 0 at once, no pulse. Key still held -> key_pulse[3] 3 frames after release of rst.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad matrix lines and debounced key outputs, grouped for the scanner and its consumer.
// The slave side is the scanner: it samples row and drives everything else.
interface keypad_scan_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] key_state;
    logic [15:0] key_pulse;
    logic [15:0] key_release;
    logic        frame_done;

    modport master (
        output row,
        input  col, key_state, key_pulse, key_release, frame_done
    );

    modport slave (
        input  row,
        output col, key_state, key_pulse, key_release, frame_done
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with per-key frame-count debounce; key index = row*4 + col.
// Press/release pulses come one cycle after the column-3 capture, alongside frame_done; there is no backpressure.
module keypad_scan #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic         clk,
    input  logic         rst,
    keypad_scan_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS) + 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS - 1);

    logic [3:0]    r_row_s1;
    logic [3:0]    r_row_s2;
    logic [DW-1:0] r_div_cnt;
    logic [1:0]    r_col_sel;
    logic [3:0]    r_col;
    logic [15:0]   r_raw;
    logic          r_eval;
    logic [15:0]   r_state;
    logic [15:0]   r_pulse;
    logic [15:0]   r_release;
    logic          r_frame_done;
    logic [CW-1:0] r_cnt [16];

    logic          w_slot_end;
    logic [15:0]   w_flip;
    logic [CW-1:0] w_cnt_nxt [16];

    assign w_slot_end = (r_div_cnt == DIV_MAX);

    // Rows are asynchronous to clk; only the second flop output is ever looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_s1 <= 4'b1111;
            r_row_s2 <= 4'b1111;
        end else begin
            r_row_s1 <= bus.row;
            r_row_s2 <= r_row_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_col_sel <= 2'd0;
            r_col     <= 4'b1110;
            r_raw     <= '0;
            r_eval    <= 1'b0;
        end else begin
            r_div_cnt <= w_slot_end ? '0 : r_div_cnt + 1'b1;
            if (w_slot_end) begin
                for (int r = 0; r < 4; r++) begin
                    r_raw[{2'(r), r_col_sel}] <= ~r_row_s2[r];
                end
                r_col_sel <= r_col_sel + 2'd1;
                r_col     <= ~(4'b0001 << (r_col_sel + 2'd1));
            end
            r_eval <= w_slot_end && (r_col_sel == 2'd3);
        end
    end

    // A key flips only after DEBOUNCE_SCANS consecutive frames disagree with its debounced level.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_flip[i]    = 1'b0;
            w_cnt_nxt[i] = r_cnt[i];
            if (r_raw[i] == r_state[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_flip[i]    = 1'b1;
                w_cnt_nxt[i] = '0;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= '0;
            r_pulse      <= '0;
            r_release    <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_frame_done <= r_eval;
            r_pulse      <= '0;
            r_release    <= '0;
            if (r_eval) begin
                for (int i = 0; i < 16; i++) begin
                    r_cnt[i] <= w_cnt_nxt[i];
                end
                r_state   <= r_state ^ w_flip;
                r_pulse   <= w_flip & r_raw;
                r_release <= w_flip & ~r_raw;
            end
        end
    end

    assign bus.col         = r_col;
    assign bus.key_state   = r_state;
    assign bus.key_pulse   = r_pulse;
    assign bus.key_release = r_release;
    assign bus.frame_done  = r_frame_done;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key matrix model drives rows from the scanned column, and a
// per-frame debounce reference predicts key_state / key_pulse / key_release at every frame_done.
module tb_keypad_scan;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;
    int          n_asrt = 0;
    int          n_fail = 0;

    logic [15:0] m_state;
    int          m_run [16];

    keypad_scan_if kb ();

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (kb)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a pressed key sits in the column being driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            kb.row[r] = ~|(pressed[r*4 +: 4] & ~kb.col);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = '0;
        for (int i = 0; i < 16; i++) m_run[i] = 0;
    endtask

    // A key's level changes once it has been seen opposite to its level for DEB frames in a row.
    task automatic model_frame(input logic [15:0] raw, output logic [15:0] ep, output logic [15:0] er);
        ep = '0;
        er = '0;
        for (int i = 0; i < 16; i++) begin
            if (raw[i] != m_state[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DEB) begin
                    m_run[i]   = 0;
                    m_state[i] = raw[i];
                    if (raw[i]) ep[i] = 1'b1;
                    else        er[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    task automatic run_frame(input int exp_cyc);
        int          n;
        bit          seen;
        logic [15:0] ep;
        logic [15:0] er;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            chk("col_onecold", $countones(~kb.col), 1);
            if (kb.frame_done) seen = 1'b1;
            else chk("pulse_idle", {kb.key_pulse, kb.key_release}, 0);
        end
        if (!seen) begin
            chk("frame_timeout", 0, 1);
            return;
        end
        if (exp_cyc > 0) chk("frame_period", n, exp_cyc);
        model_frame(pressed, ep, er);
        chk("key_state", kb.key_state, m_state);
        chk("key_pulse", kb.key_pulse, ep);
        chk("key_release", kb.key_release, er);
    endtask

    initial begin
        logic [3:0] ec;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col", kb.col, 4'b1110);
        chk("rst_outs", {kb.key_state, kb.key_pulse, kb.key_release, 15'd0, kb.frame_done}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Free-running column walk and frame_done cadence after release
        for (int n = 1; n <= 49; n++) begin
            @(posedge clk);
            #1;
            ec = ~(4'b0001 << ((n / 4) % 4));
            chk("col_walk", kb.col, ec);
            chk("frame_done_cadence", kb.frame_done, (n >= 17) && ((n - 17) % 16 == 0));
            chk("idle_outs", {kb.key_state, kb.key_pulse, kb.key_release}, 0);
        end

        // Key 5 held: pulse on the third frame, then steady
        pressed = 16'h0020;
        for (int f = 0; f < 3; f++) run_frame(16);
        chk("t3_pulse", kb.key_pulse, 16'h0020);
        for (int f = 0; f < 3; f++) run_frame(16);
        pressed = '0;
        for (int f = 0; f < 3; f++) run_frame(16);
        chk("t3_release", kb.key_release, 16'h0020);

        // Key 10: two-frame glitch suppressed, three-frame press accepted
        pressed = 16'h0400;
        for (int f = 0; f < 2; f++) run_frame(16);
        pressed = '0;
        run_frame(16);
        chk("t4_no_state", kb.key_state, 16'h0000);
        pressed = 16'h0400;
        for (int f = 0; f < 3; f++) run_frame(16);
        chk("t4_pulse", kb.key_pulse, 16'h0400);
        pressed = '0;
        for (int f = 0; f < 3; f++) run_frame(16);

        // Keys 0 and 15 together
        pressed = 16'h8001;
        for (int f = 0; f < 3; f++) run_frame(16);
        chk("t5_pulse", kb.key_pulse, 16'h8001);
        pressed = '0;
        for (int f = 0; f < 3; f++) run_frame(16);
        chk("t5_release", kb.key_release, 16'h8001);

        // Reset while key 3 is two frames into its debounce
        pressed = 16'h0008;
        for (int f = 0; f < 2; f++) run_frame(16);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", {kb.key_state, kb.key_pulse, kb.key_release, 15'd0, kb.frame_done}, 0);
        chk("t6_rst_col", kb.col, 4'b1110);
        repeat (3) @(negedge clk);
        chk("t6_rst_hold", {kb.key_pulse, kb.key_release}, 0);
        rst = 1'b0;
        model_reset();
        run_frame(17);
        run_frame(16);
        run_frame(16);
        chk("t6_pulse", kb.key_pulse, 16'h0008);
        pressed = '0;
        for (int f = 0; f < 3; f++) run_frame(16);

        // Random bouncing across all keys
        for (int f = 0; f < 40; f++) begin
            pressed = pressed ^ 16'($urandom & $urandom & $urandom);
            run_frame(16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
